// File: rtl/line_index_encoder_if.sv
// ---------------------------------------------------------------------------
// line_index_encoder_if
//
// Groups the request/result signals of the 128-to-7 line index encoder.
//
// Signals:
//   start  - request a scan of vec (controller -> encoder)
//   vec    - 128-bit line vector to encode (controller -> encoder)
//   busy   - scan in progress (encoder -> controller)
//   done   - one-cycle pulse, results valid (encoder -> controller)
//   found  - at least one bit of the captured vector was set
//   index  - index of the lowest set bit, 0 when found is 0
//   multi  - more than one bit of the captured vector was set
//
// Modports:
//   master - the cache controller side that issues scans
//   slave  - the encoder itself
// ---------------------------------------------------------------------------
interface line_index_encoder_if;
    logic         start;
    logic [127:0] vec;
    logic         busy;
    logic         done;
    logic         found;
    logic [6:0]   index;
    logic         multi;

    modport master (
        output start, vec,
        input  busy, done, found, index, multi
    );

    modport slave (
        input  start, vec,
        output busy, done, found, index, multi
    );
endinterface

// File: rtl/line_index_encoder.sv
// ---------------------------------------------------------------------------
// line_index_encoder
//
// Sequential 128-to-7 priority encoder. A scan request captures the 128-bit
// line vector into a snapshot, then walks it in eight 16-bit chunks (one per
// cycle, always all eight) accumulating the lowest set bit and whether more
// than one bit is set. Results are published together with a one-cycle done
// and held until the next done.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - line_index_encoder_if.slave: start/vec in, busy/done/found/index/
//          multi out
// ---------------------------------------------------------------------------
module line_index_encoder (
    input  logic                 clk,
    input  logic                 rst,
    line_index_encoder_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]   state_q,     state_d;
    logic [2:0]   cnt_q,       cnt_d;
    logic [127:0] snap_q,      snap_d;
    logic         found_acc_q, found_acc_d;
    logic         multi_acc_q, multi_acc_d;
    logic [6:0]   index_acc_q, index_acc_d;
    logic         found_q,     found_d;
    logic         multi_q,     multi_d;
    logic [6:0]   index_q,     index_d;

    logic [15:0]  chunk;
    logic         chunk_nz;
    logic         chunk_multi;
    logic [3:0]   low_pos;
    logic         found_nx;
    logic         multi_nx;
    logic [6:0]   index_nx;
    logic         accept;

    // Evaluate the chunk selected by the counter and fold it into the
    // accumulators. chunk & (chunk-1) clears the lowest set bit, so it is
    // nonzero exactly when the chunk holds two or more ones.
    always_comb begin
        chunk       = snap_q[{cnt_q, 4'd0} +: 16];
        chunk_nz    = |chunk;
        chunk_multi = |(chunk & (chunk - 16'd1));
        low_pos     = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (chunk[i]) begin
                low_pos = 4'(i);
            end
        end
        found_nx = found_acc_q | chunk_nz;
        multi_nx = multi_acc_q | chunk_multi | (chunk_nz & found_acc_q);
        index_nx = (chunk_nz && !found_acc_q) ? {cnt_q, low_pos} : index_acc_q;
    end

    // A new request is taken only when no scan is running; DONE accepts too
    // so back-to-back requests leave no idle gap.
    assign accept = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state logic: capture on accept, step through the chunks in SCAN,
    // and publish the folded result when the last chunk is processed.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        snap_d      = snap_q;
        found_acc_d = found_acc_q;
        multi_acc_d = multi_acc_q;
        index_acc_d = index_acc_q;
        found_d     = found_q;
        multi_d     = multi_q;
        index_d     = index_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    snap_d      = bus.vec;
                    cnt_d       = 3'd0;
                    found_acc_d = 1'b0;
                    multi_acc_d = 1'b0;
                    index_acc_d = 7'd0;
                    state_d     = ST_SCAN;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_SCAN: begin
                found_acc_d = found_nx;
                multi_acc_d = multi_nx;
                index_acc_d = index_nx;
                cnt_d       = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    found_d = found_nx;
                    multi_d = multi_nx;
                    index_d = index_nx;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset abandons any scan in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            snap_q      <= '0;
            found_acc_q <= 1'b0;
            multi_acc_q <= 1'b0;
            index_acc_q <= 7'd0;
            found_q     <= 1'b0;
            multi_q     <= 1'b0;
            index_q     <= 7'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            found_acc_q <= found_acc_d;
            multi_acc_q <= multi_acc_d;
            index_acc_q <= index_acc_d;
            found_q     <= found_d;
            multi_q     <= multi_d;
            index_q     <= index_d;
        end
    end

    assign bus.busy  = (state_q == ST_SCAN);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.found = found_q;
    assign bus.multi = multi_q;
    assign bus.index = index_q;

endmodule
